ste_dma_sound_fifo: RTL and testbench

Parametrised DMA-sound sample buffer for the STE-class video/sound path. It supports 1, 2 or 4 channels and configurable depth, with mono/stereo runtime mode, and replaces the fixed 4-word, 2-channel sound FIFO inside the shifter. It requests memory words with SREQ and captures them on SLOAD_N strobes from the MCU. On each sample-rate tick it unpacks big-endian bytes into signed per-channel samples for the audio DAC/mixer.

---
 rtl/dma_snd_pkg.sv | 21 ++
 rtl/dma_snd_wordfifo.sv | 64 ++++++
 rtl/ste_dma_sound_fifo.sv | 141 ++++++++++++++
 tb/tb_ste_dma_sound_fifo.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_snd_pkg.sv
// Shared widths and helpers for the DMA-sound sample buffer.
//   SAMPLE_W    : width of one signed output sample
//   WORD_W      : width of one memory word
//   frame_bytes : bytes consumed per sample tick
//   lvl_w       : width of a word-level counter for a given depth
package dma_snd_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned WORD_W   = 16;

  // Mono, or a single channel, takes one byte per frame. Otherwise each channel takes one byte.
  function automatic int unsigned frame_bytes(input int unsigned channels, input logic mono);
    return (mono || channels == 1) ? 1 : channels;
  endfunction

  // A level counter must hold 0..depth inclusive.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dma_snd_wordfifo.sv
// Word storage for the DMA-sound buffer: one push and a 0..2 word pop per cycle.
// The three head words are exposed so that a frame starting mid-word can be unpacked.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_flush          : empty the FIFO (dominates push/pop)
//   i_push, i_wdata  : write one word
//   i_pop_cnt        : number of head words to free this cycle
//   o_rd0..o_rd2     : head, head+1, head+2 words
//   o_level          : registered word count
//   o_level_nxt_c    : combinational word count after this cycle
module dma_snd_wordfifo
  import dma_snd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_push,
  input  logic [WORD_W-1:0]       i_wdata,
  input  logic [1:0]              i_pop_cnt,
  output logic [WORD_W-1:0]       o_rd0,
  output logic [WORD_W-1:0]       o_rd1,
  output logic [WORD_W-1:0]       o_rd2,
  output logic [lvl_w(DEPTH)-1:0] o_level,
  output logic [lvl_w(DEPTH)-1:0] o_level_nxt_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = lvl_w(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  assign o_rd0 = r_mem[r_rptr];
  assign o_rd1 = r_mem[r_rptr + PW'(1)];
  assign o_rd2 = r_mem[r_rptr + PW'(2)];

  assign o_level_nxt_c = i_flush ? '0 : (o_level + LW'(i_push) - LW'(i_pop_cnt));

  // Pointer and level state.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      o_level <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      r_rptr  <= r_rptr + PW'(i_pop_cnt);
      o_level <= o_level_nxt_c;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush && !i_rst) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/ste_dma_sound_fifo.sv
// DMA-sound sample buffer. It requests words from the MCU, captures one word per
// SLOAD_N strobe and unpacks big-endian bytes into per-channel signed samples
// on every sample_tick.
//   clk32, res    : clock, synchronous active-high reset
//   enable        : playback enable, low flushes and idles
//   mono          : one byte per frame, replicated to all channels
//   sample_tick   : sample-rate strobe
//   SLOAD_N, MDIN : word-load strobe (active low) and memory data
//   SREQ          : word request to the MCU
//   sample        : CHANNELS signed bytes, channel 0 in [7:0]
//   sample_valid  : pulses when sample updates
//   level         : words stored
//   underrun      : sticky, tick with too few bytes
//   overrun       : sticky, load dropped while full
module ste_dma_sound_fifo
  import dma_snd_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CHANNELS = 2
) (
  input  logic                         clk32,
  input  logic                         res,
  input  logic                         enable,
  input  logic                         mono,
  input  logic                         sample_tick,
  input  logic                         SLOAD_N,
  input  logic [WORD_W-1:0]            MDIN,
  output logic                         SREQ,
  output logic [CHANNELS*SAMPLE_W-1:0] sample,
  output logic                         sample_valid,
  output logic [lvl_w(DEPTH)-1:0]      level,
  output logic                         underrun,
  output logic                         overrun
);

  localparam int unsigned LW = lvl_w(DEPTH);
  localparam int unsigned AW = LW + 1;

  logic                         r_sload_n_d;
  logic                         r_byte_idx;

  logic                         w_load_edge;
  logic [2:0]                   w_frame;
  logic [AW-1:0]                w_avail;
  logic                         w_tick_ok;
  logic                         w_tick_short;
  logic [2:0]                   w_consume;
  logic [1:0]                   w_pop_cnt;
  logic                         w_full;
  logic                         w_push;
  logic                         w_drop;
  logic [WORD_W-1:0]            w_rd0;
  logic [WORD_W-1:0]            w_rd1;
  logic [WORD_W-1:0]            w_rd2;
  logic [LW-1:0]                w_level_nxt;
  logic [4*SAMPLE_W-1:0]        w_shift;
  logic [CHANNELS*SAMPLE_W-1:0] w_smp;
  logic                         w_unused;

  // One capture per strobe: only the high-to-low transition counts.
  assign w_load_edge = !SLOAD_N && r_sload_n_d;

  assign w_frame      = 3'(frame_bytes(CHANNELS, mono));
  assign w_avail      = {level, 1'b0} - AW'(r_byte_idx);
  assign w_tick_ok    = enable && sample_tick && (w_avail >= AW'(w_frame));
  assign w_tick_short = enable && sample_tick && (w_avail <  AW'(w_frame));

  // Byte position after the frame: whole words crossed are freed, the LSB is the new byte_idx.
  assign w_consume = {2'b00, r_byte_idx} + w_frame;
  assign w_pop_cnt = w_tick_ok ? w_consume[2:1] : 2'd0;

  // A full FIFO still accepts a word when the same cycle frees one.
  assign w_full = (level == LW'(DEPTH));
  assign w_push = enable && w_load_edge && (!w_full || (w_pop_cnt != 2'd0));
  assign w_drop = enable && w_load_edge && w_full && (w_pop_cnt == 2'd0);

  dma_snd_wordfifo #(
    .DEPTH (DEPTH)
  ) u_wordfifo (
    .i_clk         (clk32),
    .i_rst         (res),
    .i_flush       (!enable),
    .i_push        (w_push),
    .i_wdata       (MDIN),
    .i_pop_cnt     (w_pop_cnt),
    .o_rd0         (w_rd0),
    .o_rd1         (w_rd1),
    .o_rd2         (w_rd2),
    .o_level       (level),
    .o_level_nxt_c (w_level_nxt)
  );

  // Big-endian byte window starting at the next unconsumed byte. A 4-byte frame that starts
  // on a low byte spans three words.
  assign w_shift = r_byte_idx ? {w_rd0[7:0], w_rd1, w_rd2[15:8]} : {w_rd0, w_rd1};

  // Frame byte k feeds channel k. Mono feeds frame byte 0 to every channel.
  for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_chan
    assign w_smp[k*SAMPLE_W +: SAMPLE_W] =
      mono ? w_shift[4*SAMPLE_W-1 -: SAMPLE_W]
           : w_shift[4*SAMPLE_W-1-k*SAMPLE_W -: SAMPLE_W];
  end

  assign w_unused = ^{w_rd2[7:0], w_shift};

  // Edge register, unpack state, request and sticky flags.
  always_ff @(posedge clk32) begin
    if (res) begin
      r_sload_n_d  <= 1'b1;
      r_byte_idx   <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      SREQ         <= 1'b0;
      underrun     <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      r_sload_n_d  <= SLOAD_N;
      sample_valid <= w_tick_ok;
      if (!enable) begin
        r_byte_idx <= 1'b0;
        SREQ       <= 1'b0;
        underrun   <= 1'b0;
        overrun    <= 1'b0;
      end else begin
        // Keep room for one word already in flight from the MCU.
        SREQ <= (w_level_nxt <= LW'(DEPTH - 2));
        if (w_tick_ok) begin
          sample     <= w_smp;
          r_byte_idx <= w_consume[0];
        end
        if (w_tick_short) begin
          underrun <= 1'b1;
        end
        if (w_drop) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ste_dma_sound_fifo.sv
// Bench for ste_dma_sound_fifo: a 2-channel and a 4-channel instance share one
// stimulus stream and are compared every cycle against a byte-queue reference model.
module tb_ste_dma_sound_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned BUFN  = 16;

  logic        clk32 = 1'b0;
  logic        res;
  logic        enable;
  logic        mono;
  logic        sample_tick;
  logic        SLOAD_N;
  logic [15:0] MDIN;

  logic        sreq2, valid2, ur2, or2;
  logic [15:0] smp2;
  logic [2:0]  lvl2;
  logic        sreq4, valid4, ur4, or4;
  logic [31:0] smp4;
  logic [2:0]  lvl4;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, index 0 = 2-channel, 1 = 4-channel.
  logic [7:0]  mb [2][BUFN];
  int          m_head [2];
  int          m_cnt  [2];
  logic [31:0] m_sample [2];
  logic        m_valid [2];
  logic        m_sreq  [2];
  logic        m_ur    [2];
  logic        m_or    [2];
  logic        m_prev_n;

  always #5 clk32 = ~clk32;

  ste_dma_sound_fifo #(.DEPTH(DEPTH), .CHANNELS(2)) u_dut2 (
    .clk32(clk32), .res(res), .enable(enable), .mono(mono), .sample_tick(sample_tick),
    .SLOAD_N(SLOAD_N), .MDIN(MDIN), .SREQ(sreq2), .sample(smp2), .sample_valid(valid2),
    .level(lvl2), .underrun(ur2), .overrun(or2)
  );

  ste_dma_sound_fifo #(.DEPTH(DEPTH), .CHANNELS(4)) u_dut4 (
    .clk32(clk32), .res(res), .enable(enable), .mono(mono), .sample_tick(sample_tick),
    .SLOAD_N(SLOAD_N), .MDIN(MDIN), .SREQ(sreq4), .sample(smp4), .sample_valid(valid4),
    .level(lvl4), .underrun(ur4), .overrun(or4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advances the model by one clock using the inputs sampled at this edge.
  task automatic model_step();
    logic edge_l;
    int   ch;
    int   f;
    int   pos;
    edge_l   = !SLOAD_N && m_prev_n;
    m_prev_n = res ? 1'b1 : SLOAD_N;
    for (int d = 0; d < 2; d++) begin
      ch = (d == 0) ? 2 : 4;
      if (res) begin
        m_cnt[d] = 0; m_head[d] = 0; m_sample[d] = '0;
        m_valid[d] = 1'b0; m_sreq[d] = 1'b0; m_ur[d] = 1'b0; m_or[d] = 1'b0;
      end else if (!enable) begin
        m_cnt[d] = 0;
        m_valid[d] = 1'b0; m_sreq[d] = 1'b0; m_ur[d] = 1'b0; m_or[d] = 1'b0;
      end else begin
        f = mono ? 1 : ch;
        m_valid[d] = 1'b0;
        if (sample_tick) begin
          if (m_cnt[d] >= f) begin
            for (int k = 0; k < ch; k++) begin
              pos = (m_head[d] + (mono ? 0 : k)) % BUFN;
              m_sample[d][8*k +: 8] = mb[d][pos];
            end
            m_head[d]  = (m_head[d] + f) % BUFN;
            m_cnt[d]   = m_cnt[d] - f;
            m_valid[d] = 1'b1;
          end else begin
            m_ur[d] = 1'b1;
          end
        end
        if (edge_l) begin
          // Words held = bytes rounded up to whole words.
          if ((m_cnt[d] + 1) / 2 < int'(DEPTH)) begin
            mb[d][(m_head[d] + m_cnt[d]) % BUFN]     = MDIN[15:8];
            mb[d][(m_head[d] + m_cnt[d] + 1) % BUFN] = MDIN[7:0];
            m_cnt[d] = m_cnt[d] + 2;
          end else begin
            m_or[d] = 1'b1;
          end
        end
        m_sreq[d] = (int'(DEPTH) - (m_cnt[d] + 1) / 2) >= 2;
      end
    end
  endtask

  task automatic check_all();
    check_eq("c2.sample",   32'(smp2),   m_sample[0]);
    check_eq("c2.valid",    32'(valid2), 32'(m_valid[0]));
    check_eq("c2.level",    32'(lvl2),   32'((m_cnt[0] + 1) / 2));
    check_eq("c2.sreq",     32'(sreq2),  32'(m_sreq[0]));
    check_eq("c2.underrun", 32'(ur2),    32'(m_ur[0]));
    check_eq("c2.overrun",  32'(or2),    32'(m_or[0]));
    check_eq("c4.sample",   smp4,        m_sample[1]);
    check_eq("c4.valid",    32'(valid4), 32'(m_valid[1]));
    check_eq("c4.level",    32'(lvl4),   32'((m_cnt[1] + 1) / 2));
    check_eq("c4.sreq",     32'(sreq4),  32'(m_sreq[1]));
    check_eq("c4.underrun", 32'(ur4),    32'(m_ur[1]));
    check_eq("c4.overrun",  32'(or4),    32'(m_or[1]));
  endtask

  task automatic step();
    @(posedge clk32);
    model_step();
    #1;
    check_all();
  endtask

  task automatic load(input logic [15:0] w, input int len, input logic with_tick);
    SLOAD_N = 1'b0;
    MDIN = w;
    sample_tick = with_tick;
    step();
    sample_tick = 1'b0;
    for (int i = 1; i < len; i++) step();
    SLOAD_N = 1'b1;
    MDIN = 16'($urandom);
    step();
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic flush();
    enable = 1'b0;
    step();
    enable = 1'b1;
  endtask

  initial begin
    logic [15:0] hold2;
    int strobe;
    int gap;
    res = 1'b1; enable = 1'b1; mono = 1'b0; sample_tick = 1'b0; SLOAD_N = 1'b1; MDIN = '0;
    m_prev_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_head[d] = 0; m_cnt[d] = 0;
    end
    step();
    step();
    check_eq("rst.sample4", smp4, 32'h0);
    check_eq("rst.sreq2", 32'(sreq2), 32'h0);
    res = 1'b0;
    step();

    // Stereo basics.
    load(16'h1234, 2, 1'b0);
    load(16'h5680, 2, 1'b0);
    check_eq("st.level", 32'(lvl2), 32'd2);
    check_eq("st.sreq", 32'(sreq2), 32'd1);
    tick();
    check_eq("st.s1", 32'(smp2), 32'h3412);
    check_eq("st.l1", 32'(lvl2), 32'd1);
    check_eq("st.c4", smp4, 32'h80563412);
    tick();
    check_eq("st.s2", 32'(smp2), 32'h8056);
    check_eq("st.l2", 32'(lvl2), 32'd0);

    // Mono with four channels.
    flush();
    mono = 1'b1;
    load(16'hAB7F, 3, 1'b0);
    tick();
    check_eq("mono.s1", smp4, 32'hABABABAB);
    tick();
    check_eq("mono.s2", smp4, 32'h7F7F7F7F);
    tick();
    check_eq("mono.hold", smp4, 32'h7F7F7F7F);
    check_eq("mono.valid", 32'(valid4), 32'd0);
    check_eq("mono.ur", 32'(ur4), 32'd1);

    // Four-channel frames.
    flush();
    mono = 1'b0;
    load(16'h0102, 1, 1'b0);
    tick();
    check_eq("q4.ur", 32'(ur4), 32'd1);
    load(16'h0304, 1, 1'b0);
    tick();
    check_eq("q4.s", smp4, 32'h04030201);
    check_eq("q4.l", 32'(lvl4), 32'd0);

    // Long strobe and full FIFO.
    flush();
    load(16'hCAFE, 8, 1'b0);
    check_eq("strobe.l", 32'(lvl2), 32'd1);
    load(16'h1111, 1, 1'b0);
    load(16'h2222, 2, 1'b0);
    load(16'h3333, 3, 1'b0);
    check_eq("full.l", 32'(lvl2), 32'd4);
    check_eq("full.sreq", 32'(sreq2), 32'd0);
    load(16'hBEEF, 2, 1'b0);
    check_eq("drop.l", 32'(lvl2), 32'd4);
    check_eq("drop.or", 32'(or2), 32'd1);
    load(16'hF00D, 2, 1'b1);
    check_eq("accept.l", 32'(lvl2), 32'd4);

    // Flush mid-strobe.
    flush();
    tick();
    load(16'h4444, 1, 1'b0);
    load(16'h5555, 1, 1'b0);
    SLOAD_N = 1'b0;
    MDIN = 16'h6666;
    step();
    check_eq("fl.pre", 32'(lvl2), 32'd3);
    check_eq("fl.ur_pre", 32'(ur2), 32'd1);
    hold2 = smp2;
    enable = 1'b0;
    step();
    check_eq("fl.level", 32'(lvl2), 32'd0);
    check_eq("fl.sreq", 32'(sreq2), 32'd0);
    check_eq("fl.ur", 32'(ur2), 32'd0);
    check_eq("fl.sample", 32'(smp2), 32'(hold2));
    enable = 1'b1;
    step();
    SLOAD_N = 1'b1;
    step();
    check_eq("fl.nocap", 32'(lvl2), 32'd0);

    // Randomised traffic.
    strobe = 0;
    gap = 0;
    for (int i = 0; i < 3000; i++) begin
      res = ($urandom_range(0, 999) == 0);
      enable = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 199) == 0) mono = ~mono;
      sample_tick = ($urandom_range(0, 3) == 0);
      if (strobe > 0) begin
        SLOAD_N = 1'b0;
        strobe--;
      end else if (gap > 0) begin
        SLOAD_N = 1'b1;
        gap--;
      end else begin
        strobe = int'($urandom_range(1, 4)) - 1;
        gap = int'($urandom_range(1, 3));
        SLOAD_N = 1'b0;
        MDIN = 16'($urandom);
      end
      step();
    end

    // Final reset clears the samples.
    res = 1'b1;
    sample_tick = 1'b0;
    SLOAD_N = 1'b1;
    step();
    check_eq("rst2.s2", 32'(smp2), 32'h0);
    check_eq("rst2.s4", smp4, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
